// File: rtl/transmit_slot_dispatcher.sv
// Transmit slot dispatcher: pops 9-bit frame words ({eof, payload}) from the shared
// transmit queue and steers each whole frame to one transmit slot, picked round-robin.
// Frames longer than MAX_FRAME_WORDS are cut with a forced end marker. The rest of the
// frame then follows as a new frame.
module transmit_slot_dispatcher #(
  parameter int unsigned TRANSMIT_QUE_SLOTS = 4,
  parameter int unsigned MAX_FRAME_WORDS    = 2048
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [8:0]                          pop_data,
  input  logic                                pop_data_valid,
  output logic                                pop_ready,
  input  logic [TRANSMIT_QUE_SLOTS-1:0]       slot_ready,
  output logic [TRANSMIT_QUE_SLOTS-1:0]       enable,
  output logic [TRANSMIT_QUE_SLOTS-1:0][8:0]  data,
  output logic [TRANSMIT_QUE_SLOTS-1:0]       data_enable,
  output logic                                truncated
);

  localparam int unsigned SelW = (TRANSMIT_QUE_SLOTS > 1) ? $clog2(TRANSMIT_QUE_SLOTS) : 1;
  localparam int unsigned CntW = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [SelW-1:0] LastSlot = SelW'(TRANSMIT_QUE_SLOTS - 1);
  // word_count value while the final permitted word of a frame is being popped
  localparam logic [CntW-1:0] LastWord = CntW'(MAX_FRAME_WORDS - 1);

  typedef enum logic [0:0] {StIdle, StPassthrough} state_e;

  state_e                                state_q, state_d;
  logic [SelW-1:0]                       slot_sel_q, slot_sel_d;
  logic [CntW-1:0]                       word_cnt_q, word_cnt_d;
  logic [TRANSMIT_QUE_SLOTS-1:0]         enable_q, enable_d;
  logic [TRANSMIT_QUE_SLOTS-1:0][8:0]    data_q, data_d;
  logic [TRANSMIT_QUE_SLOTS-1:0]         data_en_q, data_en_d;
  logic                                  trunc_q, trunc_d;

  logic            pop;
  logic [SelW-1:0] sel_next;

  // Round-robin successor; a single slot wraps onto itself.
  assign sel_next  = (slot_sel_q == LastSlot) ? '0 : slot_sel_q + 1'b1;
  assign pop_ready = (state_q == StPassthrough) && slot_ready[slot_sel_q];
  assign pop       = pop_data_valid && pop_ready;

  assign enable      = enable_q;
  assign data        = data_q;
  assign data_enable = data_en_q;
  assign truncated   = trunc_q;

  // Next-state logic: slot scan while idle, word forwarding and frame termination.
  always_comb begin
    state_d    = state_q;
    slot_sel_d = slot_sel_q;
    word_cnt_d = word_cnt_q;
    enable_d   = enable_q;
    data_d     = data_q;
    data_en_d  = '0;
    trunc_d    = 1'b0;
    case (state_q)
      StIdle: begin
        // The pointer only scans while there is something to dispatch.
        if (pop_data_valid) begin
          if (slot_ready[slot_sel_q]) begin
            state_d    = StPassthrough;
            enable_d   = TRANSMIT_QUE_SLOTS'(1) << slot_sel_q;
            word_cnt_d = '0;
          end else begin
            slot_sel_d = sel_next;
          end
        end
      end
      StPassthrough: begin
        if (pop) begin
          data_d[slot_sel_q]    = pop_data;
          data_en_d[slot_sel_q] = 1'b1;
          word_cnt_d            = word_cnt_q + 1'b1;
          if (pop_data[8] || (word_cnt_q == LastWord)) begin
            state_d    = StIdle;
            enable_d   = '0;
            slot_sel_d = sel_next;
            // Length limit hit without a real end marker: close the frame here.
            if (!pop_data[8]) begin
              data_d[slot_sel_q][8] = 1'b1;
              trunc_d               = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers, cleared asynchronously so a reset abandons any frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      slot_sel_q <= '0;
      word_cnt_q <= '0;
      enable_q   <= '0;
      data_q     <= '0;
      data_en_q  <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_sel_q <= slot_sel_d;
      word_cnt_q <= word_cnt_d;
      enable_q   <= enable_d;
      data_q     <= data_d;
      data_en_q  <= data_en_d;
      trunc_q    <= trunc_d;
    end
  end

endmodule

// File: tb/tb_transmit_slot_dispatcher.sv
// Bench for transmit_slot_dispatcher: directed scenarios plus a randomized run checked
// against a frame-level model (frames split at end markers / length limit, chunks dealt
// to slots in round-robin order).
module tb_transmit_slot_dispatcher;

  localparam int unsigned NSLOT = 4;
  localparam int unsigned MAXW  = 4;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b1;
  logic [8:0]             pop_data = '0;
  logic                   pop_data_valid = 1'b0;
  logic                   pop_ready;
  logic [NSLOT-1:0]       slot_ready = '1;
  logic [NSLOT-1:0]       enable;
  logic [NSLOT-1:0][8:0]  data;
  logic [NSLOT-1:0]       data_enable;
  logic                   truncated;

  int tests_run = 0;
  int tests_failed = 0;

  logic [8:0]       src_q [$];
  logic             src_gate = 1'b1;
  logic [9:0]       cap_q [NSLOT][$];  // {truncated, data} seen per slot
  logic [9:0]       exp_q [NSLOT][$];
  int               trunc_cnt = 0;
  int               onehot_err = 0;
  logic [NSLOT-1:0] prev_en = '0;
  logic [NSLOT-1:0] en_seen = '0;

  transmit_slot_dispatcher #(
    .TRANSMIT_QUE_SLOTS(NSLOT),
    .MAX_FRAME_WORDS   (MAXW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pop_data      (pop_data),
    .pop_data_valid(pop_data_valid),
    .pop_ready     (pop_ready),
    .slot_ready    (slot_ready),
    .enable        (enable),
    .data          (data),
    .data_enable   (data_enable),
    .truncated     (truncated)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic load_src();
    pop_data_valid = src_gate && (src_q.size() != 0);
    pop_data       = (src_q.size() != 0) ? src_q[0] : 9'h000;
  endtask

  task automatic clear_caps();
    for (int s = 0; s < NSLOT; s++) begin
      cap_q[s].delete();
      exp_q[s].delete();
    end
    trunc_cnt  = 0;
    onehot_err = 0;
    prev_en    = '0;
    en_seen    = '0;
  endtask

  // One clock: handshake sampled before the edge, outputs recorded at the next negedge.
  task automatic step();
    logic hs;
    #1;
    hs = pop_data_valid && pop_ready && reset_n;
    @(posedge clock);
    if (hs) void'(src_q.pop_front());
    @(negedge clock);
    for (int s = 0; s < NSLOT; s++)
      if (data_enable[s]) cap_q[s].push_back({truncated, data[s]});
    if (truncated) trunc_cnt++;
    if ($countones(enable) > 1 || (data_enable & ~prev_en) != '0) onehot_err++;
    prev_en = enable;
    en_seen = en_seen | enable;
    load_src();
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (src_q.size() == 0 && enable == '0 && data_enable == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    src_q.delete();
    src_gate   = 1'b1;
    slot_ready = '1;
    load_src();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    clear_caps();
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 1'b0;
    src_q.push_back(9'h055);
    load_src();
    #1;
    tests_run++;
    if (enable !== '0 || data_enable !== '0) begin
      tests_failed++;
      $display("FAIL reset_enables: enable=%b data_enable=%b expected 0", enable, data_enable);
    end
    tests_run++;
    if (data !== '0 || truncated !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_data: data=%h truncated=%b expected 0", data, truncated);
    end
    tests_run++;
    if (pop_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pop_ready: got %b expected 0", pop_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    tests_run++;
    if (pop_ready !== 1'b0 || enable !== '0) begin
      tests_failed++;
      $display("FAIL reset_release: pop_ready=%b enable=%b expected 0", pop_ready, enable);
    end
    src_q.delete();
    load_src();
    clear_caps();
  endtask

  task automatic test_single_frame();
    bit ok;
    clear_caps();
    src_q.push_back(9'h011);
    src_q.push_back(9'h022);
    src_q.push_back(9'h133);
    src_q.push_back(9'h1AA);
    load_src();
    step();
    tests_run++;
    if (enable !== 4'b0001 || data_enable !== '0) begin
      tests_failed++;
      $display("FAIL single_grant: enable=%b data_enable=%b expected 0001/0000",
               enable, data_enable);
    end
    step();
    tests_run++;
    if (data_enable !== 4'b0001 || data[0] !== 9'h011) begin
      tests_failed++;
      $display("FAIL single_w0: de=%b data0=%h expected 0001/011", data_enable, data[0]);
    end
    step();
    tests_run++;
    if (data_enable !== 4'b0001 || data[0] !== 9'h022) begin
      tests_failed++;
      $display("FAIL single_w1: de=%b data0=%h expected 0001/022", data_enable, data[0]);
    end
    step();
    tests_run++;
    if (data_enable !== 4'b0001 || data[0] !== 9'h133 || enable !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_w2: de=%b data0=%h enable=%b expected 0001/133/0000",
               data_enable, data[0], enable);
    end
    drain(40, ok);
    tests_run++;
    if (!ok || cap_q[1].size() != 1 || cap_q[0].size() != 3) begin
      tests_failed++;
      $display("FAIL single_next_slot: ok=%0d slot1 words=%0d slot0 words=%0d expected 1/1/3",
               ok, cap_q[1].size(), cap_q[0].size());
    end else if (cap_q[1][0] !== 10'h1AA) begin
      tests_failed++;
      $display("FAIL single_next_word: got %h expected 1aa", cap_q[1][0]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      logic [7:0] b;
      b = 8'(f * 16);
      src_q.push_back({1'b0, b + 8'h01});
      src_q.push_back({1'b1, b + 8'h02});
      exp_q[f % NSLOT].push_back({2'b00, b + 8'h01});
      exp_q[f % NSLOT].push_back({2'b01, b + 8'h02});
    end
    load_src();
    drain(80, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rr_timeout: frames not drained within 80 cycles");
    end
    for (int s = 0; s < NSLOT; s++) begin
      tests_run++;
      if (cap_q[s].size() != exp_q[s].size()) begin
        tests_failed++;
        $display("FAIL rr_count slot%0d: got %0d words expected %0d",
                 s, cap_q[s].size(), exp_q[s].size());
      end else begin
        for (int i = 0; i < exp_q[s].size(); i++)
          if (cap_q[s][i] !== exp_q[s][i]) begin
            tests_failed++;
            $display("FAIL rr_word slot%0d[%0d]: got %h expected %h",
                     s, i, cap_q[s][i], exp_q[s][i]);
            break;
          end
      end
    end
    tests_run++;
    if (onehot_err != 0) begin
      tests_failed++;
      $display("FAIL rr_onehot: %0d violations expected 0", onehot_err);
    end
  endtask

  task automatic test_skip_busy();
    bit ok;
    do_reset();
    slot_ready = 4'b1101;
    src_q.push_back(9'h155);
    src_q.push_back(9'h061);
    src_q.push_back(9'h162);
    load_src();
    step();
    step();
    step();
    tests_run++;
    if (enable !== 4'b0000) begin
      tests_failed++;
      $display("FAIL skip_scan: enable=%b expected 0000", enable);
    end
    step();
    tests_run++;
    if (enable !== 4'b0100) begin
      tests_failed++;
      $display("FAIL skip_grant: enable=%b expected 0100", enable);
    end
    drain(40, ok);
    tests_run++;
    if (!ok || cap_q[1].size() != 0 || en_seen !== 4'b0101) begin
      tests_failed++;
      $display("FAIL skip_slot1: ok=%0d slot1 words=%0d enables seen=%b expected 1/0/0101",
               ok, cap_q[1].size(), en_seen);
    end
    tests_run++;
    if (cap_q[2].size() != 2 || cap_q[2][0] !== 10'h061 || cap_q[2][1] !== 10'h162) begin
      tests_failed++;
      $display("FAIL skip_data: slot2 words=%0d expected 061,162", cap_q[2].size());
    end
    slot_ready = '1;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [9:0] want [4];
    want = '{10'h0A1, 10'h0A2, 10'h0A3, 10'h1A4};
    do_reset();
    for (int i = 0; i < 4; i++) src_q.push_back(want[i][8:0]);
    load_src();
    step();
    step();
    slot_ready = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (pop_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_pop_ready cycle%0d: got %b expected 0", i, pop_ready);
      end
      step();
      tests_run++;
      if (enable !== 4'b0001 || (i > 0 && data_enable !== '0)) begin
        tests_failed++;
        $display("FAIL bp_hold cycle%0d: enable=%b de=%b expected 0001/0000",
                 i, enable, data_enable);
      end
    end
    slot_ready = '1;
    drain(40, ok);
    tests_run++;
    if (!ok || cap_q[0].size() != 4 || trunc_cnt != 0) begin
      tests_failed++;
      $display("FAIL bp_count: ok=%0d words=%0d truncs=%0d expected 1/4/0",
               ok, cap_q[0].size(), trunc_cnt);
    end else begin
      for (int i = 0; i < 4; i++)
        if (cap_q[0][i] !== want[i]) begin
          tests_failed++;
          $display("FAIL bp_order[%0d]: got %h expected %h", i, cap_q[0][i], want[i]);
          break;
        end
    end
  endtask

  task automatic test_truncation();
    bit ok;
    do_reset();
    for (int i = 1; i <= 5; i++) src_q.push_back({1'b0, 8'hB0 + 8'(i)});
    src_q.push_back(9'h1B6);
    load_src();
    drain(60, ok);
    tests_run++;
    if (!ok || trunc_cnt != 1) begin
      tests_failed++;
      $display("FAIL trunc_pulse: ok=%0d pulses=%0d expected 1/1", ok, trunc_cnt);
    end
    tests_run++;
    if (cap_q[0].size() != 4 || cap_q[0][3] !== 10'h3B4 || cap_q[0][2] !== 10'h0B3) begin
      tests_failed++;
      $display("FAIL trunc_cut: slot0 words=%0d expected 4 ending 0b3,3b4 (pulse+eof)",
               cap_q[0].size());
    end
    tests_run++;
    if (cap_q[1].size() != 2 || cap_q[1][0] !== 10'h0B5 || cap_q[1][1] !== 10'h1B6) begin
      tests_failed++;
      $display("FAIL trunc_rest: slot1 words=%0d expected 0b5,1b6", cap_q[1].size());
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    do_reset();
    src_q.push_back(9'h0C1);
    src_q.push_back(9'h0C2);
    src_q.push_back(9'h0C3);
    src_q.push_back(9'h1C4);
    load_src();
    step();
    step();
    step();
    tests_run++;
    if (data_enable !== 4'b0001 || data[0] !== 9'h0C2) begin
      tests_failed++;
      $display("FAIL rstmid_pre: de=%b data0=%h expected 0001/0c2", data_enable, data[0]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (enable !== '0 || data_enable !== '0 || pop_ready !== 1'b0 || data !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_async: enable=%b de=%b pop_ready=%b expected all 0",
               enable, data_enable, pop_ready);
    end
    src_q.delete();
    load_src();
    @(negedge clock);
    reset_n = 1'b1;
    clear_caps();
    src_q.push_back(9'h0D1);
    src_q.push_back(9'h1D2);
    load_src();
    drain(40, ok);
    tests_run++;
    if (!ok || en_seen !== 4'b0001 || cap_q[0].size() != 2 || cap_q[0][0] !== 10'h0D1) begin
      tests_failed++;
      $display("FAIL rstmid_restart: ok=%0d enables seen=%b slot0 words=%0d expected 1/0001/2",
               ok, en_seen, cap_q[0].size());
    end
  endtask

  task automatic test_random();
    int  chunk;
    int  cnt;
    bit  ok;
    do_reset();
    chunk = 0;
    cnt   = 0;
    for (int f = 0; f < 30; f++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int w = 0; w < len; w++) begin
        logic [7:0] pl;
        logic       last;
        pl   = 8'($urandom_range(0, 255));
        last = (w == len - 1);
        src_q.push_back({last, pl});
        cnt++;
        if (last) begin
          exp_q[chunk % NSLOT].push_back({2'b01, pl});
          chunk++;
          cnt = 0;
        end else if (cnt == MAXW) begin
          exp_q[chunk % NSLOT].push_back({2'b11, pl});
          chunk++;
          cnt = 0;
        end else begin
          exp_q[chunk % NSLOT].push_back({2'b00, pl});
        end
      end
    end
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      src_gate   = ($urandom_range(0, 4) != 0);
      slot_ready = (enable == '0) ? '1 : NSLOT'($urandom());
      load_src();
      step();
      if (src_q.size() == 0 && enable == '0 && data_enable == '0) begin
        ok = 1'b1;
        break;
      end
    end
    src_gate   = 1'b1;
    slot_ready = '1;
    load_src();
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rand_timeout: %0d words left after 3000 cycles", src_q.size());
    end
    for (int s = 0; s < NSLOT; s++) begin
      tests_run++;
      if (cap_q[s].size() != exp_q[s].size()) begin
        tests_failed++;
        $display("FAIL rand_count slot%0d: got %0d words expected %0d",
                 s, cap_q[s].size(), exp_q[s].size());
      end
      for (int i = 0; i < cap_q[s].size() && i < exp_q[s].size(); i++) begin
        tests_run++;
        if (cap_q[s][i] !== exp_q[s][i]) begin
          tests_failed++;
          $display("FAIL rand_word slot%0d[%0d]: got %h expected %h",
                   s, i, cap_q[s][i], exp_q[s][i]);
        end
      end
    end
    tests_run++;
    if (onehot_err != 0) begin
      tests_failed++;
      $display("FAIL rand_onehot: %0d violations expected 0", onehot_err);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_skip_busy();
    test_backpressure();
    test_truncation();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
